// File: rtl/sum4b_display.sv
// Captures the 4-bit adder operands and {Co,S} result and scans them onto a
// 4-digit multiplexed 7-segment display: A hex, B hex, result as two decimal digits.
module sum4b_display #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter bit COMMON_ANODE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] S,
   input  logic       Co,
   input  logic       load,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int DIV = CLK_HZ / REFRESH_HZ;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
   localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF : 4'h0;
   localparam logic       DP_OFF  = COMMON_ANODE;

   logic [3:0]       ra, rb;
   logic [4:0]       rr;
   logic [CNT_W-1:0] presc;
   logic [1:0]       idx;
   logic             tick;
   logic [1:0]       tens;
   logic [3:0]       units;
   logic [6:0]       seg_nxt;
   logic             dp_nxt;
   logic [3:0]       an_nxt;

   // Active-high {g,f,e,d,c,b,a} glyphs for hex digits.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 7'b0111111;
         4'h1: glyph = 7'b0000110;
         4'h2: glyph = 7'b1011011;
         4'h3: glyph = 7'b1001111;
         4'h4: glyph = 7'b1100110;
         4'h5: glyph = 7'b1101101;
         4'h6: glyph = 7'b1111101;
         4'h7: glyph = 7'b0000111;
         4'h8: glyph = 7'b1111111;
         4'h9: glyph = 7'b1101111;
         4'hA: glyph = 7'b1110111;
         4'hB: glyph = 7'b1111100;
         4'hC: glyph = 7'b0111001;
         4'hD: glyph = 7'b1011110;
         4'hE: glyph = 7'b1111001;
         default: glyph = 7'b1110001;
      endcase
   endfunction

   assign tick = (presc == CNT_MAX);

   // Capture stage and scan control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra    <= '0;
         rb    <= '0;
         rr    <= '0;
         presc <= '0;
         idx   <= '0;
      end else begin
         if (load) begin
            ra <= A;
            rb <= B;
            rr <= {Co, S};
         end
         presc <= tick ? '0 : presc + CNT_W'(1);
         if (tick)
            idx <= idx + 2'd1;
      end
   end

   // Result is at most 31, so a three-way compare is enough for the decimal split.
   always_comb begin
      if (rr >= 5'd30) begin
         tens  = 2'd3;
         units = 4'(rr - 5'd30);
      end else if (rr >= 5'd20) begin
         tens  = 2'd2;
         units = 4'(rr - 5'd20);
      end else if (rr >= 5'd10) begin
         tens  = 2'd1;
         units = 4'(rr - 5'd10);
      end else begin
         tens  = 2'd0;
         units = rr[3:0];
      end
   end

   always_comb begin
      seg_nxt = '0;
      dp_nxt  = 1'b0;
      an_nxt  = 4'b0001 << idx;
      case (idx)
         2'd0: seg_nxt = glyph(units);
         2'd1: begin
            seg_nxt = (tens == 2'd0) ? 7'b0000000 : glyph({2'b00, tens});
            dp_nxt  = rr[4];
         end
         2'd2: seg_nxt = glyph(rb);
         default: seg_nxt = glyph(ra);
      endcase
   end

   // Output stage: polarity applied before the register so pins are glitch-free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         dp  <= DP_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= seg_nxt ^ SEG_OFF;
         dp  <= dp_nxt ^ DP_OFF;
         an  <= an_nxt ^ AN_OFF;
      end
   end

endmodule

// File: tb/tb_sum4b_display.sv
// Directed bench for sum4b_display with DIV=4 and active-high outputs.
module tb_sum4b_display;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] A = '0, B = '0, S = '0;
   logic       Co = 1'b0, load = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int checks = 0;
   int failures = 0;

   localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011,
                          G3 = 7'b1001111, G4 = 7'b1100110, G5 = 7'b1101101,
                          G6 = 7'b1111101, G7 = 7'b0000111, G9 = 7'b1101111,
                          GF = 7'b1110001, BLK = 7'b0000000;

   sum4b_display #(.CLK_HZ(8), .REFRESH_HZ(2), .COMMON_ANODE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .S(S), .Co(Co), .load(load),
      .seg(seg), .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_disp(input string tag, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
      check({tag, ".an"}, 32'(an), 32'(e_an));
      check({tag, ".seg"}, 32'(seg), 32'(e_seg));
      check({tag, ".dp"}, 32'(dp), 32'(e_dp));
   endtask

   // One clock edge; outputs are sampled on the following falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asserts reset mid-cycle, confirms outputs drop without a clock edge, releases on a falling edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_disp({tag, ".rst"}, 4'b0000, BLK, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                        input logic co, input logic ld);
      A = a; B = b; S = s; Co = co; load = ld;
   endtask

   // Checks edges 2..16 after reset release: rest of digit 0, then digits 1, 2, 3 for 4 cycles each.
   task automatic scan4(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input logic d1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_disp({tag, ".d0"}, 4'b0001, s0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         check_disp({tag, ".d1"}, 4'b0010, s1, d1);
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         check_disp({tag, ".d2"}, 4'b0100, s2, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         check_disp({tag, ".d3"}, 4'b1000, s3, 1'b0);
      end
   endtask

   initial begin
      // Reset and the all-zero display
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) cyc();
      do_reset("t1");
      cyc();
      check_disp("t1.first", 4'b0001, G0, 1'b0);
      scan4("t1", G0, BLK, G0, G0, 1'b0);

      // Load 9 + 7 = 16 and one full scan
      do_reset("t2");
      apply(4'h9, 4'h7, 4'h0, 1'b1, 1'b1);
      cyc();
      check_disp("t2.lag", 4'b0001, G0, 1'b0);
      load = 1'b0;
      scan4("t2", G6, G1, G7, G9, 1'b1);
      cyc();
      check_disp("t2.wrap", 4'b0001, G6, 1'b0);

      // Leading-zero blanking: 3 + 4 = 7
      do_reset("t3");
      apply(4'h3, 4'h4, 4'h7, 1'b0, 1'b1);
      cyc();
      load = 1'b0;
      scan4("t3", G7, BLK, G4, G3, 1'b0);

      // Maximum result 31
      do_reset("t4");
      apply(4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
      cyc();
      load = 1'b0;
      scan4("t4", G1, G3, GF, GF, 1'b1);

      // Load coinciding with the tick edge (prescaler = 3 before edge 4)
      do_reset("t5");
      apply(4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
      cyc();
      load = 1'b0;
      cyc();
      check_disp("t5.old2", 4'b0001, G1, 1'b0);
      cyc();
      check_disp("t5.old3", 4'b0001, G1, 1'b0);
      apply(4'h1, 4'h2, 4'h5, 1'b0, 1'b1);
      cyc();
      check_disp("t5.prior", 4'b0001, G1, 1'b0);
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check_disp("t5.new_d1", 4'b0010, BLK, 1'b0);
      end
      cyc();
      check_disp("t5.new_d2", 4'b0100, G2, 1'b0);
      repeat (3) cyc();
      cyc();
      check_disp("t5.new_d3", 4'b1000, G1, 1'b0);
      repeat (3) cyc();
      cyc();
      check_disp("t5.new_d0", 4'b0001, G5, 1'b0);

      // Hold with load low, then reset during digit 2
      do_reset("t6");
      apply(4'h9, 4'h7, 4'h0, 1'b1, 1'b1);
      cyc();
      apply(4'h3, 4'h4, 4'h7, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_disp("t6.hold_d0", 4'b0001, G6, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         check_disp("t6.hold_d1", 4'b0010, G1, 1'b1);
      end
      cyc();
      check_disp("t6.hold_d2", 4'b0100, G7, 1'b0);
      cyc();
      do_reset("t6.mid");
      cyc();
      check_disp("t6.first", 4'b0001, G0, 1'b0);
      scan4("t6.post", G0, BLK, G0, G0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
